// File: rtl/snoop_responder.sv
// snoop_responder: bus-side MSI snoop controller for one CPU node.
// Watches coherence-bus messages issued by other nodes, downgrades or
// invalidates the matching local cache block, and writes a Modified block
// back to memory through a request/acknowledge handshake before the update.
module snoop_responder (
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] bus_in,
    input  logic       own_request,
    input  logic [1:0] state_cb1,
    input  logic [1:0] state_cb2,
    input  logic [2:0] address_cb1,
    input  logic [2:0] address_cb2,
    input  logic [3:0] data_cb1,
    input  logic [3:0] data_cb2,
    input  logic       wb_ack,
    output logic       write_cb1,
    output logic       write_cb2,
    output logic [1:0] state_cb,
    output logic [2:0] address_cb,
    output logic [3:0] data_cb,
    output logic       wb_req,
    output logic [2:0] wb_address,
    output logic [3:0] wb_data,
    output logic       busy,
    output logic       done,
    output logic       protocol_error
);

    localparam logic [1:0] OP_READ_MISS  = 2'b00;
    localparam logic [1:0] OP_WRITE_MISS = 2'b01;
    localparam logic [1:0] OP_WRITE_BACK = 2'b11;

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        LOOKUP    = 2'b01,
        WRITEBACK = 2'b10,
        UPDATE    = 2'b11
    } fsm_t;

    fsm_t       state_q, state_d;
    logic [1:0] op_q;
    logic [2:0] addr_q;
    logic [3:0] data_q;
    logic [1:0] new_state_q, new_state_d;
    logic       done_q, done_d;
    logic       perr_q, perr_set;

    logic [1:0] sel_state;
    logic [2:0] sel_tag;
    logic [3:0] sel_data;
    logic       hit;

    // Select the block addressed by the latched snoop (address[0] picks the block) and detect a hit.
    always_comb begin
        sel_state = addr_q[0] ? state_cb2   : state_cb1;
        sel_tag   = addr_q[0] ? address_cb2 : address_cb1;
        sel_data  = addr_q[0] ? data_cb2    : data_cb1;
        hit       = (sel_tag == addr_q) && ((sel_state == ST_S) || (sel_state == ST_M));
    end

    // Next-state logic; also decides the new block state, the done pulse and protocol-error detection.
    always_comb begin
        state_d     = state_q;
        new_state_d = new_state_q;
        done_d      = 1'b0;
        perr_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_in[5] && !own_request) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (!hit || (op_q == OP_WRITE_BACK)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (op_q == OP_READ_MISS) begin
                    if (sel_state == ST_M) begin
                        state_d     = WRITEBACK;
                        new_state_d = ST_S;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (op_q == OP_WRITE_MISS) begin
                    state_d     = (sel_state == ST_M) ? WRITEBACK : UPDATE;
                    new_state_d = ST_I;
                end else begin
                    // Invalidate: another node claims a block we hold Modified -- flag it, no write-back.
                    state_d     = UPDATE;
                    new_state_d = ST_I;
                    perr_set    = (sel_state == ST_M);
                end
            end
            WRITEBACK: begin
                if (wb_ack) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register plus the registered done pulse, pending new state and sticky error flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            new_state_q <= ST_I;
            done_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            new_state_q <= new_state_d;
            done_q      <= done_d;
            perr_q      <= perr_q | perr_set;
        end
    end

    // Latch the snoop op/address when a foreign message is accepted, and the block data at lookup.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_q   <= 2'b00;
            addr_q <= 3'b000;
            data_q <= 4'h0;
        end else begin
            if ((state_q == IDLE) && bus_in[5] && !own_request) begin
                op_q   <= bus_in[4:3];
                addr_q <= bus_in[2:0];
            end
            if (state_q == LOOKUP) begin
                data_q <= sel_data;
            end
        end
    end

    // Moore outputs decoded from the registered state and latches; gated to zero outside their state.
    always_comb begin
        write_cb1      = (state_q == UPDATE) && !addr_q[0];
        write_cb2      = (state_q == UPDATE) &&  addr_q[0];
        state_cb       = (state_q == UPDATE) ? new_state_q : 2'b00;
        address_cb     = (state_q == UPDATE) ? addr_q      : 3'b000;
        data_cb        = (state_q == UPDATE) ? data_q      : 4'h0;
        wb_req         = (state_q == WRITEBACK);
        wb_address     = (state_q == WRITEBACK) ? addr_q : 3'b000;
        wb_data        = (state_q == WRITEBACK) ? data_q : 4'h0;
        busy           = (state_q != IDLE);
        done           = done_q;
        protocol_error = perr_q;
    end

endmodule

// File: tb/tb_snoop_responder.sv
// Directed testbench for snoop_responder with a scoreboard of expected
// cache-block write strobes.
module tb_snoop_responder;

    logic       clock;
    logic       resetn;
    logic [5:0] bus_in;
    logic       own_request;
    logic [1:0] state_cb1, state_cb2;
    logic [2:0] address_cb1, address_cb2;
    logic [3:0] data_cb1, data_cb2;
    logic       wb_ack;
    logic       write_cb1, write_cb2;
    logic [1:0] state_cb;
    logic [2:0] address_cb;
    logic [3:0] data_cb;
    logic       wb_req;
    logic [2:0] wb_address;
    logic [3:0] wb_data;
    logic       busy, done, protocol_error;

    typedef struct {
        logic       blk2;
        logic [1:0] st;
        logic [2:0] addr;
        logic [3:0] data;
    } strobe_t;

    strobe_t exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    snoop_responder dut (
        .clock          (clock),
        .resetn         (resetn),
        .bus_in         (bus_in),
        .own_request    (own_request),
        .state_cb1      (state_cb1),
        .state_cb2      (state_cb2),
        .address_cb1    (address_cb1),
        .address_cb2    (address_cb2),
        .data_cb1       (data_cb1),
        .data_cb2       (data_cb2),
        .wb_ack         (wb_ack),
        .write_cb1      (write_cb1),
        .write_cb2      (write_cb2),
        .state_cb       (state_cb),
        .address_cb     (address_cb),
        .data_cb        (data_cb),
        .wb_req         (wb_req),
        .wb_address     (wb_address),
        .wb_data        (wb_data),
        .busy           (busy),
        .done           (done),
        .protocol_error (protocol_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [21:0] all_outs();
        return {write_cb1, write_cb2, state_cb, address_cb, data_cb, wb_req,
                wb_address, wb_data, busy, done, protocol_error};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present a bus message for one sampling edge, then clear the bus.
    task automatic send(input logic [5:0] msg);
        bus_in = msg;
        tick();
        bus_in = 6'b0;
    endtask

    // Wait (bounded) for a write strobe, check it against the scoreboard, then check done.
    task automatic wait_strobe(input string tag, input int exp_wait);
        int w;
        strobe_t e;
        w = 0;
        while (!(write_cb1 || write_cb2) && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_wait"}, w, exp_wait);
        chk({tag, "_qsize"}, exp_q.size(), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_blk"}, {write_cb2, write_cb1}, e.blk2 ? 2'b10 : 2'b01);
            chk({tag, "_state"}, state_cb, e.st);
            chk({tag, "_addr"}, address_cb, e.addr);
            chk({tag, "_data"}, data_cb, e.data);
        end
        chk({tag, "_nodone"}, done, 0);
        chk({tag, "_nowbreq"}, wb_req, 0);
        tick();
        chk({tag, "_done"}, done, 1);
        chk({tag, "_strobe_off"}, {write_cb1, write_cb2}, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        resetn      = 1'b0;
        bus_in      = 6'b1_00_011;
        own_request = 1'b0;
        state_cb1   = 2'b10; address_cb1 = 3'b011; data_cb1 = 4'h1;
        state_cb2   = 2'b10; address_cb2 = 3'b011; data_cb2 = 4'h5;
        wb_ack      = 1'b0;

        // Reset held with a valid message on the bus.
        repeat (3) tick();
        chk("reset_outs", all_outs(), 0);
        chk("reset_busy", busy, 0);
        bus_in = 6'b0;
        #2 resetn = 1'b1;
        repeat (3) tick();
        chk("post_reset_outs", all_outs(), 0);

        // Own-message filter.
        state_cb1 = 2'b10; address_cb1 = 3'b010; data_cb1 = 4'hA;
        own_request = 1'b1;
        bus_in = 6'b1_01_010;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("own_filter", {busy, wb_req, write_cb1, write_cb2}, 0);
        end
        own_request = 1'b0;
        bus_in = 6'b0;

        // readMiss hits M in block 2: write-back, then downgrade to S.
        state_cb2 = 2'b10; address_cb2 = 3'b011; data_cb2 = 4'h5;
        exp_q.push_back('{blk2: 1'b1, st: 2'b01, addr: 3'b011, data: 4'h5});
        send(6'b1_00_011);
        chk("rm_busy", busy, 1);
        tick();
        chk("rm_wbreq", wb_req, 1);
        chk("rm_wbaddr", wb_address, 3'b011);
        chk("rm_wbdata", wb_data, 4'h5);
        repeat (2) begin
            tick();
            chk("rm_wbreq_hold", {wb_req, write_cb2, done}, 3'b100);
        end
        wb_ack = 1'b1;
        tick();
        wb_ack = 1'b0;
        wait_strobe("rm", 0);

        // writeMiss hits S in block 1: invalidate without write-back.
        state_cb1 = 2'b01; address_cb1 = 3'b100; data_cb1 = 4'h3;
        exp_q.push_back('{blk2: 1'b0, st: 2'b00, addr: 3'b100, data: 4'h3});
        send(6'b1_01_100);
        chk("wm_s_nowb", wb_req, 0);
        wait_strobe("wm_s", 1);

        // writeMiss hits M with wb_ack already high: single-cycle request.
        state_cb1 = 2'b10; address_cb1 = 3'b000; data_cb1 = 4'hC;
        exp_q.push_back('{blk2: 1'b0, st: 2'b00, addr: 3'b000, data: 4'hC});
        send(6'b1_01_000);
        wb_ack = 1'b1;
        tick();
        chk("wm_m_wbreq", wb_req, 1);
        chk("wm_m_wbdata", wb_data, 4'hC);
        tick();
        wb_ack = 1'b0;
        wait_strobe("wm_m", 0);

        // readMiss on S in block 2: done only.
        state_cb2 = 2'b01; address_cb2 = 3'b001; data_cb2 = 4'h6;
        send(6'b1_00_001);
        tick();
        chk("rm_s_done", {done, busy, write_cb1, write_cb2, wb_req}, 5'b10000);
        tick();
        chk("rm_s_done_pulse", done, 0);

        // Tag miss on invalidate.
        state_cb1 = 2'b01; address_cb1 = 3'b010; data_cb1 = 4'h7;
        send(6'b1_10_110);
        tick();
        chk("tagmiss_done", {done, write_cb1, write_cb2, wb_req}, 4'b1000);
        tick();
        chk("tagmiss_perr", protocol_error, 0);

        // Invalidate hits M: invalidate, flag protocol error, no write-back.
        state_cb1 = 2'b10; address_cb1 = 3'b110; data_cb1 = 4'h9;
        exp_q.push_back('{blk2: 1'b0, st: 2'b00, addr: 3'b110, data: 4'h9});
        send(6'b1_10_110);
        chk("inv_m_nowb", wb_req, 0);
        wait_strobe("inv_m", 1);
        chk("inv_m_perr", protocol_error, 1);
        repeat (3) tick();
        chk("inv_m_perr_sticky", protocol_error, 1);

        // Reset while waiting for wb_ack.
        state_cb2 = 2'b10; address_cb2 = 3'b111; data_cb2 = 4'hE;
        send(6'b1_00_111);
        tick();
        chk("rst_wb_req", wb_req, 1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async", {wb_req, write_cb1, write_cb2, busy}, 0);
        wb_ack = 1'b1;
        tick();
        chk("rst_outs", all_outs(), 0);
        #2 resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_restart_idle", all_outs(), 0);
        end
        wb_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
